// File: rtl/mac_mdc_multilane_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_mdc_multilane_if
// Description : Stream bundle for the multi-lane MAC engine. Carries the two
//               LANES-wide operand streams (a, b), the accumulator seed
//               stream (c) and the result stream (d), each with an
//               AXI-Stream style TVALID/TREADY/TDATA handshake.
//               Modports:
//                 master - the side that sources a/b/c and sinks d
//                 slave  - the MAC engine itself
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_mdc_multilane_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4
);
  logic                          a_TVALID;
  logic                          a_TREADY;
  logic [LANES*DATA_WIDTH-1:0]   a_TDATA;
  logic                          b_TVALID;
  logic                          b_TREADY;
  logic [LANES*DATA_WIDTH-1:0]   b_TDATA;
  logic                          c_TVALID;
  logic                          c_TREADY;
  logic [DATA_WIDTH-1:0]         c_TDATA;
  logic                          d_TVALID;
  logic                          d_TREADY;
  logic [DATA_WIDTH-1:0]         d_TDATA;

  modport master (
    output a_TVALID, a_TDATA, b_TVALID, b_TDATA, c_TVALID, c_TDATA, d_TREADY,
    input  a_TREADY, b_TREADY, c_TREADY, d_TVALID, d_TDATA
  );

  modport slave (
    input  a_TVALID, a_TDATA, b_TVALID, b_TDATA, c_TVALID, c_TDATA, d_TREADY,
    output a_TREADY, b_TREADY, c_TREADY, d_TVALID, d_TDATA
  );
endinterface
`default_nettype wire

// File: rtl/mac_mdc_multilane.sv
`default_nettype none
// ============================================================================
// Module      : mac_mdc_multilane
// Description : Multi-lane multiply-accumulate streaming engine. Each a/b
//               beat carries LANES signed operands; the lane products are
//               summed into a registered stage (r_prod). In simple mode every
//               r_prod is shifted right and streamed to d. In dot-product mode
//               a c seed is shifted left, reg_len r_prod values are added to
//               it, and the shifted-back sum is emitted as one d beat.
// Ports       : ap_clk          clock, rising edge
//               ap_rst_n        asynchronous active-low reset
//               stream          a/b/c/d stream bundle (slave side)
//               reg_simple_mul  1 = simple mode, 0 = dot-product mode
//               reg_shift       fixed-point shift amount
//               reg_len         beats per dot product
//               busy_o          high whenever the FSM is not idle
// Options     : MAC_SATURATE_EN - when defined, narrowing to DATA_WIDTH
//               saturates; otherwise the low DATA_WIDTH bits are kept.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_mdc_multilane #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int CNT_LEN    = 4096
) (
  input  wire                            ap_clk,
  input  wire                            ap_rst_n,
  mac_mdc_multilane_if.slave             stream,
  input  wire                            reg_simple_mul,
  input  wire [$clog2(DATA_WIDTH)-1:0]   reg_shift,
  input  wire [$clog2(CNT_LEN):0]        reg_len,
  output logic                           busy_o
);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int LW = $clog2(CNT_LEN) + 1;
  localparam int PW = 2*DATA_WIDTH + $clog2(LANES);
  localparam int AW = PW + $clog2(CNT_LEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_RUN, S_OUT} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_mode;
  logic [SW-1:0]           r_shift;
  logic [LW-1:0]           r_len;
  logic [LW-1:0]           r_count;
  logic [LW-1:0]           r_issued;
  logic signed [PW-1:0]    r_prod;
  logic                    r_prod_valid;
  logic signed [AW-1:0]    r_acc;

  logic signed [2*DATA_WIDTH-1:0] w_lane_prod [LANES];
  logic signed [PW-1:0]    w_prod_sum;
  logic signed [AW-1:0]    w_c_ext, w_seed, w_prod_ext, w_out_full;
  logic                    w_simple_go, w_dot_take, w_down_ready, w_stage1_ready;
  logic                    w_ab_fire, w_c_fire, w_d_fire, w_acc_fire, w_last, w_leave_idle;

  // Narrow a wide signed value to DATA_WIDTH bits.
  function automatic logic [DATA_WIDTH-1:0] narrow(input logic signed [AW-1:0] v);
`ifdef MAC_SATURATE_EN
    // In range iff all bits from the DATA_WIDTH sign bit upward agree.
    if ((&v[AW-1:DATA_WIDTH-1]) || !(|v[AW-1:DATA_WIDTH-1]))
      return v[DATA_WIDTH-1:0];
    else if (v[AW-1])
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
    return v[DATA_WIDTH-1:0];
`endif
  endfunction

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_lane_prod[gi] = $signed(stream.a_TDATA[gi*DATA_WIDTH +: DATA_WIDTH])
                           * $signed(stream.b_TDATA[gi*DATA_WIDTH +: DATA_WIDTH]);
  end

  always_comb begin
    w_prod_sum = '0;
    for (int i = 0; i < LANES; i++)
      w_prod_sum = w_prod_sum + PW'(w_lane_prod[i]);
  end

  // Simple mode may take its first beat on the cycle it leaves IDLE.
  assign w_simple_go    = (r_state == S_IDLE && reg_simple_mul) || (r_state == S_RUN && r_mode);
  // Dot mode stops issuing once len beats are in flight or accumulated.
  assign w_dot_take     = (r_state == S_RUN) && !r_mode && (r_issued < r_len);
  // r_prod drains to d in simple mode, into the accumulator in dot mode.
  assign w_down_ready   = (r_state == S_RUN) && (r_mode ? stream.d_TREADY : 1'b1);
  assign w_stage1_ready = !r_prod_valid || w_down_ready;
  assign w_ab_fire      = stream.a_TVALID && stream.b_TVALID && w_stage1_ready
                          && (w_simple_go || w_dot_take);
  assign w_c_fire       = (r_state == S_SEED) && stream.c_TVALID;
  assign w_acc_fire     = r_prod_valid && (r_state == S_RUN) && !r_mode;
  assign w_last         = w_acc_fire && ((r_count + LW'(1)) == r_len);
  assign w_d_fire       = stream.d_TVALID && stream.d_TREADY;
  assign w_leave_idle   = (r_state == S_IDLE) && (w_state_nxt != S_IDLE);

  assign w_c_ext    = AW'($signed(stream.c_TDATA));
  assign w_seed     = w_c_ext <<< r_shift;
  assign w_prod_ext = AW'(r_prod);
  assign w_out_full = (r_state == S_OUT) ? (r_acc >>> r_shift) : (w_prod_ext >>> r_shift);

  always_comb begin
    w_state_nxt      = r_state;
    stream.a_TREADY  = w_ab_fire;
    stream.b_TREADY  = w_ab_fire;
    stream.c_TREADY  = 1'b0;
    stream.d_TVALID  = 1'b0;
    stream.d_TDATA   = narrow(w_out_full);
    busy_o           = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (reg_simple_mul)       w_state_nxt = S_RUN;
        else if (stream.c_TVALID) w_state_nxt = S_SEED;
      end
      S_SEED: begin
        stream.c_TREADY = 1'b1;
        if (stream.c_TVALID) w_state_nxt = (r_len == '0) ? S_OUT : S_RUN;
      end
      S_RUN: begin
        if (r_mode) begin
          stream.d_TVALID = r_prod_valid;
          // Leave simple mode only once nothing is in flight.
          if (!reg_simple_mul && !r_prod_valid && !w_ab_fire) w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        stream.d_TVALID = 1'b1;
        if (stream.d_TREADY) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_shift      <= '0;
      r_len        <= '0;
      r_count      <= '0;
      r_issued     <= '0;
      r_prod       <= '0;
      r_prod_valid <= 1'b0;
      r_acc        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_leave_idle) begin
        r_mode  <= reg_simple_mul;
        r_shift <= reg_shift;
        r_len   <= reg_len;
      end
      if (w_ab_fire) begin
        r_prod       <= w_prod_sum;
        r_prod_valid <= 1'b1;
      end else if (r_prod_valid && w_down_ready) begin
        r_prod_valid <= 1'b0;
      end
      if (w_c_fire) begin
        r_acc    <= w_seed;
        r_count  <= '0;
        r_issued <= '0;
      end else begin
        if (w_acc_fire) begin
          r_acc   <= r_acc + AW'(r_prod);
          r_count <= r_count + LW'(1);
        end
        if (w_ab_fire && w_dot_take) r_issued <= r_issued + LW'(1);
        if (w_d_fire && r_state == S_OUT) r_acc <= '0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mac_mdc_multilane.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_mdc_multilane
// Description : Directed self-checking bench for mac_mdc_multilane
//               (DATA_WIDTH=32, LANES=4, CNT_LEN=8). Honours MAC_SATURATE_EN
//               for the overflow expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_mdc_multilane;
  localparam int DW = 32;
  localparam int LN = 4;
  localparam int CL = 8;
  localparam int SW = $clog2(DW);
  localparam int LW = $clog2(CL) + 1;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          reg_simple_mul = 1'b0;
  logic [SW-1:0] reg_shift = '0;
  logic [LW-1:0] reg_len = '0;
  logic          busy_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [LN*DW-1:0] a_vec [8];
  logic [LN*DW-1:0] b_vec [8];
  logic [DW-1:0]    e_vec [8];

  mac_mdc_multilane_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

  mac_mdc_multilane #(.DATA_WIDTH(DW), .LANES(LN), .CNT_LEN(CL)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .stream         (bus),
    .reg_simple_mul (reg_simple_mul),
    .reg_shift      (reg_shift),
    .reg_len        (reg_len),
    .busy_o         (busy_o)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LN*DW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [LN*DW-1:0] rep(input int v);
    return {v, v, v, v};
  endfunction

  task automatic present(input int i);
    bus.a_TVALID = 1'b1;
    bus.b_TVALID = 1'b1;
    bus.a_TDATA  = a_vec[i];
    bus.b_TDATA  = b_vec[i];
  endtask

  // Simple-mode burst of n beats from the vector tables; optional d stall
  // of 'stall' cycles once the first result shows up.
  task automatic stream(input string tag, input int n, input int stall);
    int sent, recv, held, first_v, first_d, last_d;
    logic ab_f, d_f;
    logic [DW-1:0] held_d;
    sent = 0; recv = 0; held = 0; first_v = -1; first_d = -1; last_d = -1; held_d = '0;
    reg_simple_mul = 1'b1;
    bus.d_TREADY = (stall == 0);
    present(0);
    #1;
    for (int cyc = 0; cyc < 100 && recv < n; cyc++) begin
      if (bus.d_TVALID && first_v < 0) first_v = cyc;
      if (stall > 0 && bus.d_TVALID && held < stall) begin
        if (held == 0) held_d = bus.d_TDATA;
        else check({tag, "_stall_d"}, bus.d_TDATA, held_d);
        check({tag, "_stall_ab_ready"}, bus.a_TREADY, 0);
        held++;
        if (held == stall) begin
          bus.d_TREADY = 1'b1;
          #1;
        end
      end
      ab_f = bus.a_TVALID && bus.a_TREADY;
      d_f  = bus.d_TVALID && bus.d_TREADY;
      if (d_f) begin
        check({tag, "_d"}, bus.d_TDATA, e_vec[recv]);
        if (first_d < 0) first_d = cyc;
        last_d = cyc;
        recv++;
      end
      @(posedge ap_clk); #1;
      if (ab_f) sent++;
      if (sent < n) present(sent);
      else begin
        bus.a_TVALID = 1'b0;
        bus.b_TVALID = 1'b0;
      end
      #1;
    end
    check({tag, "_count"}, recv, n);
    check({tag, "_latency"}, first_v, 1);
    check({tag, "_consecutive"}, last_d - first_d, n - 1);
    bus.d_TREADY = 1'b0;
  endtask

  task automatic leave_simple(input string tag);
    reg_simple_mul = 1'b0;
    bus.a_TVALID = 1'b0;
    bus.b_TVALID = 1'b0;
    for (int k = 0; k < 20 && busy_o; k++) begin
      @(posedge ap_clk); #1;
    end
    check({tag, "_busy_lo"}, busy_o, 0);
  endtask

  task automatic wait_c(input string tag, inout int fires);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (bus.c_TVALID && bus.c_TREADY) got = 1'b1;
      if (bus.a_TVALID && bus.a_TREADY) fires++;
      @(posedge ap_clk); #1;
    end
    check({tag, "_c_accept"}, got, 1);
  endtask

  // One dot product. If hold_c, c_next is offered during the run and must
  // wait; it is then still valid for the following dot() call.
  task automatic dot(input string tag, input logic [DW-1:0] c, input int len, input int sh,
                     input int av, input int bv, input logic [DW-1:0] exp,
                     input bit hold_c, input logic [DW-1:0] c_next);
    int fires;
    bit seen;
    fires = 0; seen = 1'b0;
    reg_simple_mul = 1'b0;
    reg_len = LW'(len);
    reg_shift = SW'(sh);
    bus.c_TVALID = 1'b1;
    bus.c_TDATA = c;
    bus.d_TREADY = 1'b0;
    bus.a_TDATA = rep(av);
    bus.b_TDATA = rep(bv);
    bus.a_TVALID = 1'b1;
    bus.b_TVALID = 1'b1;
    #1;
    wait_c(tag, fires);
    bus.c_TVALID = hold_c;
    bus.c_TDATA = c_next;
    reg_len = LW'(len + 2);   // must be ignored: config is latched
    #1;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (bus.d_TVALID) seen = 1'b1;
      else begin
        if (hold_c) check({tag, "_c_wait"}, bus.c_TREADY, 0);
        if (bus.a_TVALID && bus.a_TREADY) fires++;
        @(posedge ap_clk); #1;
        if (fires >= len) begin
          bus.a_TVALID = 1'b0;
          bus.b_TVALID = 1'b0;
        end
        #1;
      end
    end
    check({tag, "_d_seen"}, seen, 1);
    check({tag, "_beats"}, fires, len);
    check({tag, "_d"}, bus.d_TDATA, exp);
    check({tag, "_busy_hi"}, busy_o, 1);
    @(posedge ap_clk); #1;
    check({tag, "_d_hold_valid"}, bus.d_TVALID, 1);
    check({tag, "_d_hold"}, bus.d_TDATA, exp);
    bus.a_TVALID = 1'b0;
    bus.b_TVALID = 1'b0;
    bus.d_TREADY = 1'b1;
    @(posedge ap_clk); #1;
    bus.d_TREADY = 1'b0;
    #1;
    check({tag, "_busy_done"}, busy_o, 0);
    check({tag, "_d_valid_done"}, bus.d_TVALID, 0);
  endtask

  task automatic reset_state_checks(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_d_valid"}, bus.d_TVALID, 0);
    check({tag, "_d_data"}, bus.d_TDATA, 0);
    check({tag, "_a_ready"}, bus.a_TREADY, 0);
    check({tag, "_b_ready"}, bus.b_TREADY, 0);
    check({tag, "_c_ready"}, bus.c_TREADY, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fires;
    logic [DW-1:0] ovf_exp;
    bus.a_TVALID = 1'b0; bus.b_TVALID = 1'b0; bus.c_TVALID = 1'b0; bus.d_TREADY = 1'b0;
    bus.a_TDATA = '0; bus.b_TDATA = '0; bus.c_TDATA = '0;

    repeat (3) @(posedge ap_clk);
    #1;
    reset_state_checks("reset");
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Simple mode, shift 0: 1*5+2*6+3*7+4*8 = 70
    a_vec[0] = pack(1, 2, 3, 4); b_vec[0] = pack(5, 6, 7, 8); e_vec[0] = 32'd70;
    stream("simple1", 1, 0);

    // 8 back-to-back beats: (i+1)*(1+2+3+4)
    for (int i = 0; i < 8; i++) begin
      a_vec[i] = rep(i + 1); b_vec[i] = pack(1, 2, 3, 4); e_vec[i] = DW'(10 * (i + 1));
    end
    stream("simple8", 8, 0);

    // Backpressure: 2i+3+8+15 = 2i+26
    for (int i = 0; i < 4; i++) begin
      a_vec[i] = pack(i, 1, 2, 3); b_vec[i] = pack(2, 3, 4, 5); e_vec[i] = DW'(2 * i + 26);
    end
    stream("bp", 4, 5);

    // Overflow: 4*(2^31-1)^2 = 2^64 - 2^34 + 4
`ifdef MAC_SATURATE_EN
    ovf_exp = 32'h7FFF_FFFF;
`else
    ovf_exp = 32'h0000_0004;
`endif
    a_vec[0] = rep(32'h7FFF_FFFF); b_vec[0] = rep(32'h7FFF_FFFF); e_vec[0] = ovf_exp;
    stream("ovf", 1, 0);

    // Shift 2 in simple mode: 70>>>2 = 17, -15>>>2 = -4
    leave_simple("exit1");
    reg_shift = SW'(2);
    a_vec[0] = pack(1, 2, 3, 4);  b_vec[0] = pack(5, 6, 7, 8); e_vec[0] = 32'd17;
    a_vec[1] = pack(-3, 0, 0, 0); b_vec[1] = pack(5, 0, 0, 0); e_vec[1] = 32'hFFFF_FFFC;
    stream("shift2", 2, 0);
    leave_simple("exit2");

    // Dot products
    dot("dot3",    32'd10,   3, 0, 1,  1 + 1, 32'd34,        1'b1, 32'hFFFF_FFFB);
    dot("dot0",    -5,       0, 2, 1,  1,     32'hFFFF_FFFB, 1'b0, 32'd0);
    dot("dotmax",  32'd3,    CL, 0, 1, 1,     32'd35,        1'b0, 32'd0);
    dot("dotneg",  -100,     2, 1, 3,  -2,    -124,          1'b0, 32'd0);

    // Reset in the middle of a 4-beat dot product
    reg_simple_mul = 1'b0; reg_len = LW'(4); reg_shift = '0;
    bus.c_TVALID = 1'b1; bus.c_TDATA = 32'd7; bus.d_TREADY = 1'b0;
    bus.a_TDATA = rep(1); bus.b_TDATA = rep(1); bus.a_TVALID = 1'b1; bus.b_TVALID = 1'b1;
    #1;
    fires = 0;
    wait_c("rst_run", fires);
    bus.c_TVALID = 1'b0;
    #1;
    for (int k = 0; k < 20 && fires < 2; k++) begin
      if (bus.a_TVALID && bus.a_TREADY) fires++;
      @(posedge ap_clk); #1;
    end
    check("rst_run_two_beats", fires, 2);
    check("rst_run_busy", busy_o, 1);
    ap_rst_n = 1'b0;
    #1;
    reset_state_checks("midrst");
    bus.a_TVALID = 1'b0; bus.b_TVALID = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    #1;
    dot("postrst", 32'd0, 1, 0, 1, 1, 32'd4, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mac_mdc_multilane.md
Name: mac_mdc_multilane

Overview:
- Parametrised multi-lane multiply-accumulate streaming engine; successor of the single-lane 32b MAC kernel.
- Each a/b beat carries LANES signed operands per stream. Per-lane products are summed by a registered reduction stage, then either streamed out directly or accumulated over reg_len beats on top of a shifted c seed.
- Sits in the accelerator kernel behind the streamer, with AXI-Stream-style TVALID/TREADY/TDATA ports.

Parameters:
- DATA_WIDTH, 32: signed width of each operand lane and of c and d.
- LANES, 4: operands per a/b beat; power of two, at least 1.
- CNT_LEN, 4096: maximum dot-product length in beats; power of two.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- a_TVALID/a_TREADY/a_TDATA  in/out/in  1/1/LANES*DATA_WIDTH  operand stream a; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- b_TVALID/b_TREADY/b_TDATA  in/out/in  1/1/LANES*DATA_WIDTH  operand stream b, same layout as a.
- c_TVALID/c_TREADY/c_TDATA  in/out/in  1/1/DATA_WIDTH  accumulator seed stream.
- d_TVALID/d_TREADY/d_TDATA  out/in/out  1/1/DATA_WIDTH  result stream.
- reg_simple_mul  in  1  1 = simple mode; 0 = dot-product mode.
- reg_shift  in  $clog2(DATA_WIDTH)  fixed-point shift amount.
- reg_len  in  $clog2(CNT_LEN)+1  number of beats per dot product.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, ap_clk. Reset ap_rst_n is asynchronous and active-low.
- Reset values: all valids 0, all TREADY 0, d_TDATA 0, busy_o 0, FSM in IDLE, counter 0, accumulator 0.
- Widths:
  - PW = 2*DATA_WIDTH + $clog2(LANES).
  - AW = PW + $clog2(CNT_LEN) + 1.
  - All arithmetic is signed.
- Stage 1 (r_prod):
  - Loads the sum of LANES signed products on an a&b handshake.
  - a_TREADY = b_TREADY = a_TVALID & b_TVALID & stage1_ready & (FSM in RUN or simple mode). Both streams are therefore consumed in the same cycle, never one alone.
  - stage1_ready = ~r_prod_valid | downstream_ready.
- FSM states: IDLE, SEED, RUN, OUT. Configuration (mode, shift, len) is latched on leaving IDLE and held until the FSM returns to IDLE; changes mid-operation are ignored.
- Simple mode (reg_simple_mul=1):
  - FSM leaves IDLE for RUN and stays there.
  - d_TDATA = r_prod >>> shift, narrowed to DATA_WIDTH.
  - d_TVALID = r_prod_valid. Latency is 1 cycle from the a/b handshake to d_TVALID.
  - Sustains 1 beat/cycle while d_TREADY=1.
  - c is never consumed; c_TREADY=0.
  - Returns to IDLE only when reg_simple_mul=0 and the pipe is empty.
- Dot mode (reg_simple_mul=0):
  - IDLE -> SEED when c_TVALID=1.
  - SEED: c_TREADY=1. On the handshake, acc = sign-extended c << shift, counter = 0.
    - Next state is RUN if latched len > 0, otherwise OUT.
  - RUN: each r_prod handshake does acc += r_prod and counter++. When the accumulated count reaches len, go to OUT.
    - No a/b beat beyond len beats is accepted while in RUN.
  - OUT: d_TVALID=1, d_TDATA = acc >>> shift, narrowed.
    - Value is held stable until d_TREADY. On the handshake, go to IDLE and clear acc.
  - Latency: d_TVALID is asserted 1 cycle after the last r_prod handshake.
- Handshake rules:
  - Valids never drop without a handshake.
  - Data is stable while valid && !ready.
  - d_TREADY low stalls back to a/b/c with no data loss.
- Boundaries:
  - len = 0: output is the shifted-back seed.
  - len = CNT_LEN: counter must not wrap.
  - A c beat arriving during RUN/OUT waits (c_TREADY=0).
  - shift = 0 is legal.
  - Reset mid-operation aborts immediately; no partial result is emitted.

Optional Feature:
- MAC_SATURATE_EN defined: the narrowing to DATA_WIDTH saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- MAC_SATURATE_EN undefined: the narrowing keeps the low DATA_WIDTH bits (wrap-around).

Test Plan:
- Simple mode, LANES=4, shift=0: a lanes {1,2,3,4}, b lanes {5,6,7,8}, d_TREADY=1 -> d=70 one cycle after the handshake. Back-to-back 8 beats -> 8 results on consecutive cycles.
- Dot mode, len=3, shift=0: c=10, then 3 beats each with all lanes a=1, b=2 -> single d=10+3*8=34; busy_o drops after the d handshake.
- Dot mode, len=0: c=-5, shift=2 -> d=-5 and no a/b beat is consumed.
- Backpressure: simple mode with d_TREADY held 0 for 5 cycles during a 4-beat burst -> a_TREADY low while the pipe is full, d_TDATA stable; all 4 results delivered in order after release.
- Overflow: DATA_WIDTH=32, simple mode, a=b=0x7FFFFFFF in all lanes, shift=0 -> d=0x7FFFFFFF with MAC_SATURATE_EN, low 32 bits of the sum without.
- Reset asserted during RUN after 2 of 4 beats -> all outputs return to reset values immediately. A following dot-product run (c=0, len=1, a=b=1 in all lanes) gives d=LANES.
